// File: rtl/inst_uncache_burst_pkg.sv
// Shared constants for the uncached instruction-fetch burst bridge and its AR queue.
package inst_uncache_burst_pkg;

    localparam logic [3:0] I_UNCACHE_ARID = 4'd2;
    localparam logic [1:0] BURST_INCR     = 2'b01;
    localparam logic [2:0] SIZE_4B        = 3'b010;
    localparam int         WORD_W         = 32;
    localparam int         ADDR_TAG_W     = 30;

    function automatic logic [3:0] arlen_of(input int beats);
        return 4'(beats - 1);
    endfunction

endpackage

// File: rtl/inst_uncache_fifo.sv
// Small synchronous FIFO with occupancy count; holds word-aligned fetch addresses awaiting AR issue.
module inst_uncache_fifo
    import inst_uncache_burst_pkg::*;
#(
    parameter int WIDTH = ADDR_TAG_W,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];

    // A pop frees the head slot in the same cycle, so a push into a full FIFO is allowed then.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/inst_uncache_burst.sv
// Uncached instruction-fetch bridge: BEATS-word INCR bursts, up to OUTSTANDING in-order fetches,
// fetch cancel by counting completions to discard, and AXI read-error reporting.
module inst_uncache_burst
    import inst_uncache_burst_pkg::*;
#(
    parameter int         BEATS       = 2,
    parameter int         OUTSTANDING = 2,
    parameter logic [3:0] ARID        = I_UNCACHE_ARID
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    inst_req,
    input  logic [31:0]             inst_addr,
    input  logic                    inst_cancel,
    output logic                    inst_addr_ok,
    output logic                    inst_data_ok,
    output logic [WORD_W*BEATS-1:0] inst_rdata,
    output logic                    inst_err,
    output logic [3:0]              arid,
    output logic [31:0]             araddr,
    output logic [3:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [1:0]              arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic [3:0]              arqos,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [3:0]              rid,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] OUT_MAX  = CNT_W'(OUTSTANDING);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BEATS - 1);

    logic [CNT_W-1:0]         out_cnt;
    logic [CNT_W-1:0]         drop_cnt;
    logic [IDX_W-1:0]         beat_idx;
    logic                     err_acc;
    logic                     ovf;
    logic [WORD_W-1:0]        words_q [BEATS];
    logic [WORD_W*BEATS-1:0]  words_next;

    logic                     accept;
    logic                     ar_pop;
    logic [ADDR_TAG_W-1:0]    ar_head;
    logic                     ar_full;
    logic                     ar_empty;
    logic [CNT_W-1:0]         ar_count;
    logic                     beat_hit;
    logic                     done;
    logic                     emit;
    logic                     unused_bits;

    // Handshakes: a transfer happens on a cycle where valid & ready; once arvalid rises, araddr is
    // the FIFO head and stays put until arready; rready is tied high so every R beat is taken.
    assign accept       = inst_req & ~inst_cancel & (out_cnt < OUT_MAX) & ~ar_full;
    assign inst_addr_ok = accept;
    assign ar_pop       = arready & ~ar_empty;

    inst_uncache_fifo #(
        .WIDTH (ADDR_TAG_W),
        .DEPTH (OUTSTANDING)
    ) u_ar_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (accept),
        .push_data (inst_addr[31:2]),
        .pop       (ar_pop),
        .pop_data  (ar_head),
        .full      (ar_full),
        .empty     (ar_empty),
        .count     (ar_count)
    );

    assign arvalid = ~ar_empty;
    assign araddr  = {ar_head, 2'b00};
    assign arid    = ARID;
    assign arlen   = arlen_of(BEATS);
    assign arsize  = SIZE_4B;
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arqos   = 4'b0000;
    assign rready  = 1'b1;

    assign unused_bits = ^{inst_addr[1:0], rresp[0], ar_count};

    // A stray rlast with nothing outstanding still resets the collector but completes nothing.
    assign beat_hit = rvalid & (rid == ARID);
    assign done     = beat_hit & rlast & (out_cnt != '0);
    assign emit     = done & (drop_cnt == '0) & ~inst_cancel;

    always_comb begin
        words_next = '0;
        for (int i = 0; i < BEATS; i++) begin
            words_next[WORD_W*i +: WORD_W] = (beat_hit && beat_idx == IDX_W'(i)) ? rdata : words_q[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_cnt      <= '0;
            drop_cnt     <= '0;
            beat_idx     <= '0;
            err_acc      <= 1'b0;
            ovf          <= 1'b0;
            inst_data_ok <= 1'b0;
            inst_rdata   <= '0;
            inst_err     <= 1'b0;
            for (int i = 0; i < BEATS; i++) begin
                words_q[i] <= '0;
            end
        end else begin
            out_cnt <= out_cnt + CNT_W'(accept) - CNT_W'(done);

            // Cancel retires everything already in flight; responses are in order, so the next
            // drop_cnt completions are exactly those older fetches.
            if (inst_cancel) begin
                drop_cnt <= out_cnt - CNT_W'(done);
            end else if (done && drop_cnt != '0) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end

            if (beat_hit) begin
                words_q[beat_idx] <= rdata;
                if (rlast) begin
                    beat_idx <= '0;
                    err_acc  <= 1'b0;
                    ovf      <= 1'b0;
                end else begin
                    err_acc <= err_acc | rresp[1];
                    if (beat_idx == IDX_LAST) begin
                        ovf <= 1'b1;
                    end else begin
                        beat_idx <= beat_idx + IDX_W'(1);
                    end
                end
            end

            inst_data_ok <= emit;
            if (emit) begin
                inst_rdata <= words_next;
                inst_err   <= err_acc | ovf | rresp[1] | (beat_idx != IDX_LAST);
            end
        end
    end

endmodule

// File: tb/tb_inst_uncache_burst.sv
// Directed bench: three bridge configurations share one stimulus bus; each scenario starts from
// reset and checks the instance whose BEATS/OUTSTANDING it targets.
module tb_inst_uncache_burst;

    localparam logic [3:0] ARID_EXP   = 4'h2;
    localparam logic [3:0] FOREIGN_ID = 4'h5;

    logic        clk;
    logic        rstn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_cancel;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;

    logic        a_addr_ok, a_data_ok, a_err, a_arvalid, a_rready;
    logic [63:0] a_rdata;
    logic [3:0]  a_arid, a_arlen, a_arcache, a_arqos;
    logic [31:0] a_araddr;
    logic [2:0]  a_arsize, a_arprot;
    logic [1:0]  a_arburst, a_arlock;

    logic         b_addr_ok, b_data_ok, b_err, b_arvalid, b_rready;
    logic [127:0] b_rdata;
    logic [3:0]   b_arid, b_arlen, b_arcache, b_arqos;
    logic [31:0]  b_araddr;
    logic [2:0]   b_arsize, b_arprot;
    logic [1:0]   b_arburst, b_arlock;

    logic        c_addr_ok, c_data_ok, c_err, c_arvalid, c_rready;
    logic [63:0] c_rdata;
    logic [3:0]  c_arid, c_arlen, c_arcache, c_arqos;
    logic [31:0] c_araddr;
    logic [2:0]  c_arsize, c_arprot;
    logic [1:0]  c_arburst, c_arlock;

    int n_checks = 0;
    int n_pass   = 0;
    int c_ok_cnt = 0;
    int base_cnt;

    inst_uncache_burst #(.BEATS(2), .OUTSTANDING(1)) u_a (
        .clk(clk), .rstn(rstn), .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_addr_ok(a_addr_ok), .inst_data_ok(a_data_ok), .inst_rdata(a_rdata), .inst_err(a_err),
        .arid(a_arid), .araddr(a_araddr), .arlen(a_arlen), .arsize(a_arsize), .arburst(a_arburst),
        .arlock(a_arlock), .arcache(a_arcache), .arprot(a_arprot), .arqos(a_arqos),
        .arvalid(a_arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(a_rready)
    );

    inst_uncache_burst #(.BEATS(4), .OUTSTANDING(2)) u_b (
        .clk(clk), .rstn(rstn), .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_addr_ok(b_addr_ok), .inst_data_ok(b_data_ok), .inst_rdata(b_rdata), .inst_err(b_err),
        .arid(b_arid), .araddr(b_araddr), .arlen(b_arlen), .arsize(b_arsize), .arburst(b_arburst),
        .arlock(b_arlock), .arcache(b_arcache), .arprot(b_arprot), .arqos(b_arqos),
        .arvalid(b_arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(b_rready)
    );

    inst_uncache_burst #(.BEATS(2), .OUTSTANDING(4)) u_c (
        .clk(clk), .rstn(rstn), .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_addr_ok(c_addr_ok), .inst_data_ok(c_data_ok), .inst_rdata(c_rdata), .inst_err(c_err),
        .arid(c_arid), .araddr(c_araddr), .arlen(c_arlen), .arsize(c_arsize), .arburst(c_arburst),
        .arlock(c_arlock), .arcache(c_arcache), .arprot(c_arprot), .arqos(c_arqos),
        .arvalid(c_arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(c_rready)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (c_data_ok) c_ok_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        inst_req    = 1'b0;
        inst_addr   = 32'h0;
        inst_cancel = 1'b0;
        arready     = 1'b0;
        rid         = 4'h0;
        rdata       = 32'h0;
        rresp       = 2'b00;
        rlast       = 1'b0;
        rvalid      = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        tick();
    endtask

    // Driver tasks: one R beat per call; inputs change just after a rising edge.
    task automatic beat(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp, input logic last);
        rvalid = 1'b1;
        rid    = id;
        rdata  = d;
        rresp  = resp;
        rlast  = last;
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    task automatic burst(input logic [31:0] base, input int n, input int err_at);
        for (int i = 0; i < n; i++) begin
            beat(ARID_EXP, base + 32'(i), (i == err_at) ? 2'b10 : 2'b00, i == n - 1);
        end
    endtask

    function automatic logic [127:0] exp2(input logic [31:0] base);
        return 128'({base + 32'd1, base});
    endfunction

    function automatic logic [127:0] exp4(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    initial begin
        drive_idle();
        rstn = 1'b0;
        do_reset();

        // Reset state and constant AR fields
        inst_req = 1'b1;
        #1;
        check("rst_a_arvalid", 128'(a_arvalid), 128'(0));
        check("rst_b_arvalid", 128'(b_arvalid), 128'(0));
        check("rst_c_arvalid", 128'(c_arvalid), 128'(0));
        check("rst_a_data_ok", 128'(a_data_ok), 128'(0));
        check("rst_b_data_ok", 128'(b_data_ok), 128'(0));
        check("rst_a_err", 128'(a_err), 128'(0));
        check("rst_a_rdata", 128'(a_rdata), 128'(0));
        check("rst_b_rdata", b_rdata, 128'(0));
        check("rst_a_addr_ok", 128'(a_addr_ok), 128'(1));
        check("a_arconst", 128'({a_arid, a_arsize, a_arburst, a_arlock, a_arcache, a_arprot, a_arqos, a_rready}),
              128'({ARID_EXP, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0, 4'd0, 1'b1}));
        check("b_arconst", 128'({b_arid, b_arsize, b_arburst, b_arlock, b_arcache, b_arprot, b_arqos, b_rready}),
              128'({ARID_EXP, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0, 4'd0, 1'b1}));
        check("c_arconst", 128'({c_arid, c_arsize, c_arburst, c_arlock, c_arcache, c_arprot, c_arqos, c_rready}),
              128'({ARID_EXP, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0, 4'd0, 1'b1}));
        check("c_arlen", 128'(c_arlen), 128'(1));
        inst_req = 1'b0;

        // Single two-beat fetch, OUTSTANDING=1
        arready   = 1'b1;
        inst_req  = 1'b1;
        inst_addr = 32'hBFC00003;
        #1 check("t1_addr_ok", 128'(a_addr_ok), 128'(1));
        tick();
        inst_addr = 32'hBFC00100;
        #1;
        check("t1_addr_ok_full", 128'(a_addr_ok), 128'(0));
        check("t1_arvalid", 128'(a_arvalid), 128'(1));
        check("t1_araddr", 128'(a_araddr), 128'(32'hBFC00000));
        check("t1_arlen", 128'(a_arlen), 128'(1));
        inst_req = 1'b0;
        tick();
        check("t1_arvalid_done", 128'(a_arvalid), 128'(0));
        beat(ARID_EXP, 32'h3C1A0001, 2'b00, 1'b0);
        check("t1_no_early_ok", 128'(a_data_ok), 128'(0));
        beat(ARID_EXP, 32'h275A0002, 2'b00, 1'b1);
        check("t1_data_ok", 128'(a_data_ok), 128'(1));
        check("t1_rdata", 128'(a_rdata), 128'(64'h275A00023C1A0001));
        check("t1_err", 128'(a_err), 128'(0));
        tick();
        check("t1_ok_pulse", 128'(a_data_ok), 128'(0));
        check("t1_rdata_hold", 128'(a_rdata), 128'(64'h275A00023C1A0001));

        // Two four-beat fetches, AR ready delayed
        do_reset();
        inst_req  = 1'b1;
        inst_addr = 32'h1000;
        #1 check("t2_addr_ok0", 128'(b_addr_ok), 128'(1));
        tick();
        inst_addr = 32'h2000;
        #1 check("t2_addr_ok1", 128'(b_addr_ok), 128'(1));
        tick();
        inst_addr = 32'h3000;
        #1;
        check("t2_addr_ok_full", 128'(b_addr_ok), 128'(0));
        check("t2_arvalid", 128'(b_arvalid), 128'(1));
        check("t2_araddr0", 128'(b_araddr), 128'(32'h1000));
        check("t2_arlen", 128'(b_arlen), 128'(3));
        inst_req = 1'b0;
        tick();
        tick();
        check("t2_araddr_hold", 128'(b_araddr), 128'(32'h1000));
        arready = 1'b1;
        tick();
        check("t2_arvalid_b2b", 128'(b_arvalid), 128'(1));
        check("t2_araddr1", 128'(b_araddr), 128'(32'h2000));
        tick();
        arready = 1'b0;
        check("t2_arvalid_idle", 128'(b_arvalid), 128'(0));
        inst_req = 1'b1;
        #1 check("t2_addr_ok_still_full", 128'(b_addr_ok), 128'(0));
        inst_req = 1'b0;
        burst(32'h11110000, 4, -1);
        check("t2_ok0", 128'(b_data_ok), 128'(1));
        check("t2_rdata0", b_rdata, exp4(32'h11110000));
        check("t2_err0", 128'(b_err), 128'(0));
        burst(32'h22220000, 4, -1);
        check("t2_ok1", 128'(b_data_ok), 128'(1));
        check("t2_rdata1", b_rdata, exp4(32'h22220000));
        tick();
        check("t2_ok_pulse", 128'(b_data_ok), 128'(0));

        // Cancel with one issued and one queued fetch
        do_reset();
        arready   = 1'b1;
        inst_req  = 1'b1;
        inst_addr = 32'h1000;
        tick();
        inst_addr = 32'h2000;
        tick();
        arready     = 1'b0;
        inst_addr   = 32'h3000;
        inst_cancel = 1'b1;
        #1;
        check("t3_addr_ok_cancel", 128'(c_addr_ok), 128'(0));
        check("t3_queued_arvalid", 128'(c_arvalid), 128'(1));
        check("t3_queued_araddr", 128'(c_araddr), 128'(32'h2000));
        tick();
        inst_cancel = 1'b0;
        #1 check("t3_addr_ok_after", 128'(c_addr_ok), 128'(1));
        tick();
        inst_req = 1'b0;
        arready  = 1'b1;
        base_cnt = c_ok_cnt;
        burst(32'hC1000000, 2, -1);
        check("t3_drop0", 128'(c_data_ok), 128'(0));
        burst(32'hC2000000, 2, -1);
        check("t3_drop1", 128'(c_data_ok), 128'(0));
        burst(32'hC3000000, 2, -1);
        check("t3_ok", 128'(c_data_ok), 128'(1));
        check("t3_rdata", 128'(c_rdata), exp2(32'hC3000000));
        check("t3_err", 128'(c_err), 128'(0));
        tick();
        check("t3_ok_count", 128'(c_ok_cnt - base_cnt), 128'(1));

        // AXI error on the last beat, then a clean fetch
        do_reset();
        arready   = 1'b1;
        inst_req  = 1'b1;
        inst_addr = 32'h100;
        tick();
        inst_req = 1'b0;
        tick();
        burst(32'h55550000, 2, 1);
        check("t4_ok", 128'(a_data_ok), 128'(1));
        check("t4_err", 128'(a_err), 128'(1));
        check("t4_rdata", 128'(a_rdata), exp2(32'h55550000));
        inst_req  = 1'b1;
        inst_addr = 32'h104;
        tick();
        inst_req = 1'b0;
        tick();
        burst(32'h66660000, 2, -1);
        check("t4_ok_clean", 128'(a_data_ok), 128'(1));
        check("t4_err_clean", 128'(a_err), 128'(0));
        check("t4_rdata_clean", 128'(a_rdata), exp2(32'h66660000));

        // Foreign ID interleaved, then a short burst
        do_reset();
        arready   = 1'b1;
        inst_req  = 1'b1;
        inst_addr = 32'h200;
        tick();
        inst_req = 1'b0;
        tick();
        beat(ARID_EXP, 32'hAAAA0000, 2'b00, 1'b0);
        beat(FOREIGN_ID, 32'hDEADBEEF, 2'b10, 1'b1);
        check("t5_foreign_ignored", 128'(a_data_ok), 128'(0));
        beat(ARID_EXP, 32'hAAAA0001, 2'b00, 1'b1);
        check("t5_ok", 128'(a_data_ok), 128'(1));
        check("t5_rdata", 128'(a_rdata), exp2(32'hAAAA0000));
        check("t5_err", 128'(a_err), 128'(0));
        inst_req  = 1'b1;
        inst_addr = 32'h204;
        tick();
        inst_req = 1'b0;
        tick();
        beat(ARID_EXP, 32'h00000077, 2'b00, 1'b1);
        check("t5_short_ok", 128'(a_data_ok), 128'(1));
        check("t5_short_err", 128'(a_err), 128'(1));
        check("t5_short_rdata", 128'(a_rdata), 128'({32'hAAAA0001, 32'h00000077}));

        // Asynchronous reset in the middle of a burst
        do_reset();
        arready   = 1'b1;
        inst_req  = 1'b1;
        inst_addr = 32'h4000;
        tick();
        inst_addr = 32'h5000;
        tick();
        arready  = 1'b0;
        inst_req = 1'b0;
        beat(ARID_EXP, 32'h40000000, 2'b00, 1'b0);
        beat(ARID_EXP, 32'h40000001, 2'b00, 1'b0);
        inst_req  = 1'b1;
        inst_addr = 32'h7000;
        #1;
        check("t6_pre_addr_ok", 128'(b_addr_ok), 128'(0));
        check("t6_pre_arvalid", 128'(b_arvalid), 128'(1));
        #2 rstn = 1'b0;
        #1;
        check("t6_arvalid_cleared", 128'(b_arvalid), 128'(0));
        check("t6_data_ok_cleared", 128'(b_data_ok), 128'(0));
        check("t6_out_cnt_cleared", 128'(b_addr_ok), 128'(1));
        drive_idle();
        @(negedge clk);
        #2 rstn = 1'b1;
        tick();
        arready   = 1'b1;
        inst_req  = 1'b1;
        inst_addr = 32'h6000;
        tick();
        inst_req = 1'b0;
        tick();
        burst(32'h60000000, 4, -1);
        check("t6_ok", 128'(b_data_ok), 128'(1));
        check("t6_rdata", b_rdata, exp4(32'h60000000));
        check("t6_err", 128'(b_err), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_uncache_burst.md
# inst_uncache_burst

Parametrised uncached instruction-fetch bridge between the CPU fetch stage (sram-like, simplified) and the AXI read channel. It generalises the fixed two-beat, single-outstanding uncached path to BEATS words per fetch and up to OUTSTANDING in-order requests in flight. It adds a fetch-cancel input that silently discards the data of older requests, and reports AXI read errors. It sits beside the I-cache and shares the AXI read port through the existing arbiter, which routes responses by ARID.

## Interface
- BEATS, 2, 32-bit words per fetch (1..8); arlen = BEATS-1
- OUTSTANDING, 2, max accepted-but-not-completed fetches (1..4)
- ARID, `I_UNCACHE_ARID, AXI ID driven on arid and matched on rid
- clk  in  1  single clock, all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request
- inst_addr  in  32  fetch address; bits [1:0] ignored
- inst_cancel  in  1  one-cycle pulse; discard all fetches accepted before this cycle
- inst_addr_ok  out  1  request accepted this cycle (combinational)
- inst_data_ok  out  1  one-cycle pulse; inst_rdata/inst_err valid
- inst_rdata  out  32*BEATS  beat i at bits [32i+31:32i]
- inst_err  out  1  fetch had rresp[1]=1 on any beat, or wrong beat count
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos  out  4/32/4/3/2/2/4/3/4  AXI AR
- arvalid  out  1; arready  in  1
- rid  in  4; rdata  in  32; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1

## Operation
- Constants: arsize=2, arburst=1 (INCR), arlock/arcache/arprot/arqos=0, araddr={addr[31:2],2'b00}; rready=1 always.
- out_cnt: accepted minus completed fetches, 0..OUTSTANDING.
- inst_addr_ok = inst_req & ~inst_cancel & (out_cnt < OUTSTANDING).
- An accepted address is pushed into an AR FIFO (depth OUTSTANDING); arvalid = FIFO non-empty, araddr = FIFO head; pop on arvalid&arready. Once arvalid is high, araddr is held until handshake.
- R path: a beat counts only when rvalid & rid==ARID; other IDs are ignored.
  - beat_idx (0..BEATS-1) selects the word of a collect buffer; it saturates at BEATS-1.
  - err_acc ORs rresp[1].
  - On a counted beat with rlast: completion; beat_idx and err_acc clear.
- Completion: out_cnt decrements.
  - If drop_cnt>0: drop_cnt decrements, no data_ok.
  - Else, next cycle: inst_data_ok=1, inst_rdata = collected words, inst_err = err_acc | (beat_idx != BEATS-1 at rlast). Words not written this burst hold stale values.
- Cancel: drop_cnt <= out_cnt - (completion this cycle). Queued AR entries still issue; their data is dropped. Responses are in order (single ID), so the oldest drop_cnt completions are discarded. A new request can be accepted the cycle after cancel.
- Accept and completion in the same cycle: out_cnt unchanged.

## Timing
- Reset (async assert, sync-safe release): arvalid=0, inst_data_ok=0, inst_err=0, inst_rdata=0, out_cnt=0, drop_cnt=0, beat_idx=0, FIFO empty.
- Accept at cycle 0 → arvalid at cycle 1 at the earliest.
- Last beat at cycle t → inst_data_ok at t+1.
- inst_rdata/inst_err are stable from data_ok until the next data_ok.
- Minimum fetch latency (arready=1, first beat the cycle after AR, no R stalls): BEATS+2 cycles from accept to data_ok.
- Back-to-back: with OUTSTANDING≥2, arvalid stays high across consecutive handshakes.
- Reset mid-burst: all state cleared. The AXI side must be reset together.

## Structure
- cache_def.vh: I_UNCACHE_ARID, AXI constants (BURST_INCR, SIZE_4B).
- Sub-module inst_uncache_fifo: parametrised synchronous FIFO (WIDTH=30, DEPTH=OUTSTANDING) with full/empty/count, async active-low reset. Reusable by the data uncache path.

## Test plan
- BEATS=2, OUTSTANDING=1, addr 0xBFC00000, arready=1, beats 0x3C1A0001/0x275A0002 → araddr 0xBFC00000, arlen 1; data_ok one cycle after rlast, rdata 0x275A00023C1A0001, err=0; addr_ok low while out_cnt=1.
- BEATS=4, OUTSTANDING=2, two requests 0x1000/0x2000 on consecutive cycles, arready delayed 3 cycles → both ARs issue in order, two data_ok pulses in order, addr_ok low while two are outstanding.
- Cancel with two outstanding (one issued, one queued) → no data_ok for either. A request 0x3000 accepted the next cycle returns its data with exactly one data_ok.
- rresp=2'b10 on beat 1 of 2 → inst_err=1 with data_ok; the next clean fetch gives err=0.
- Interleaved rvalid with rid≠ARID → ignored, collected data unaffected. rlast on beat 0 with BEATS=2 → data_ok with err=1.
- rstn asserted mid-burst (asynchronously, off-edge) → arvalid and data_ok low immediately, out_cnt=0. A fresh request after release completes normally.
